// File: rtl/cnt_event_pkg.sv
// Shared types for the counter event logger: event codes, FSM states and record field widths.
package cnt_event_pkg;

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned TYPE_W = 2;

  typedef enum logic [TYPE_W-1:0] {
    EVT_CNT1_WRAP = 2'd0,
    EVT_CNT2_WRAP = 2'd1,
    EVT_JUMP      = 2'd2,
    EVT_MATCH     = 2'd3
  } evt_type_e;

  typedef enum logic [1:0] {
    StArm,
    StRun,
    StHalt
  } state_e;

  // A hold or a +1 step (mod 2^CNT_W) is normal counting; anything else is a jump.
  function automatic logic is_jump(input logic [CNT_W-1:0] prev, input logic [CNT_W-1:0] cur);
    return (cur != prev) && (cur != prev + 1'b1);
  endfunction

endpackage

// File: rtl/evt_fifo.sv
// Synchronous FIFO; push while full is accepted when a pop happens on the same edge.
module evt_fifo #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PtrW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/cnt_event_logger.sv
// Watches two 8-bit counters, turns wraps/jumps/match into timestamped records in a FIFO,
// and halts capture once counter 2 reaches the match value.
module cnt_event_logger
  import cnt_event_pkg::*;
#(
  parameter int unsigned TS_W      = 16,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MATCH_VAL = 208
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CNT_W-1:0]       cnt1_in,
  input  logic [CNT_W-1:0]       cnt2_in,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [TYPE_W+TS_W-1:0] evt_data,
  output logic                   lost,
  output logic                   done
);

  localparam logic [CNT_W-1:0] MatchVal = CNT_W'(MATCH_VAL);

  state_e           state_q;
  logic             done_q;
  logic             lost_q;
  logic [TS_W-1:0]  ts_q;
  logic [CNT_W-1:0] p1_q, p2_q;

  logic      detect_en;
  logic      wrap1, wrap2, jump, match;
  logic      push, extra, pop, drop, fifo_full, fifo_empty;
  evt_type_e evt_type;
  logic [TYPE_W+TS_W-1:0] fifo_rdata;

  assign detect_en = (state_q == StRun);
  assign wrap1 = detect_en && (p1_q == 8'hFF) && (cnt1_in == 8'h00);
  assign wrap2 = detect_en && (p2_q == 8'hFF) && (cnt2_in == 8'h00);
  assign jump  = detect_en && (is_jump(p1_q, cnt1_in) || is_jump(p2_q, cnt2_in));
  assign match = detect_en && (cnt2_in == MatchVal) && (p2_q != MatchVal);

  // Highest-priority event wins the single push slot; any other event that fired is lost.
  always_comb begin
    push     = 1'b1;
    extra    = 1'b0;
    evt_type = EVT_CNT1_WRAP;
    if (match) begin
      evt_type = EVT_MATCH;
      extra    = jump || wrap1 || wrap2;
    end else if (jump) begin
      evt_type = EVT_JUMP;
      extra    = wrap1 || wrap2;
    end else if (wrap1) begin
      evt_type = EVT_CNT1_WRAP;
      extra    = wrap2;
    end else if (wrap2) begin
      evt_type = EVT_CNT2_WRAP;
    end else begin
      push = 1'b0;
    end
  end

  assign pop  = evt_valid && evt_ready;
  assign drop = push && fifo_full && !pop;

  evt_fifo #(
    .WIDTH(TYPE_W + TS_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .wdata({evt_type, ts_q}),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign evt_valid = !fifo_empty;
  assign evt_data  = evt_valid ? fifo_rdata : '0;
  assign lost      = lost_q;
  assign done      = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StArm;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StArm: state_q <= StRun;
        StRun: begin
          if (match) begin
            state_q <= StHalt;
            done_q  <= 1'b1;
          end
        end
        StHalt: state_q <= StHalt;
        default: state_q <= StArm;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q   <= '0;
      lost_q <= 1'b0;
      p1_q   <= '0;
      p2_q   <= '0;
    end else begin
      ts_q   <= ts_q + 1'b1;
      lost_q <= lost_q || extra || drop;
      p1_q   <= cnt1_in;
      p2_q   <= cnt2_in;
    end
  end

endmodule
